// File: rtl/led_pattern_sequencer_pkg.sv
// Package: led_seq_pkg
// Shared types and constants for the LED pattern sequencer.
//   mode_t  : requested pattern mode (all four 2-bit codes defined)
//   state_t : sequencer FSM states
//   PAT_*   : pattern loaded when a mode is (re)started
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [3:0] PAT_OFF    = 4'b0000;
   localparam logic [3:0] PAT_CHASE  = 4'b0001;
   localparam logic [3:0] PAT_BOUNCE = 4'b0001;
   localparam logic [3:0] PAT_BLINK  = 4'b1111;

   function automatic logic [3:0] init_pattern(input mode_t m);
      logic [3:0] p;
      p = PAT_OFF;
      case (m)
         MODE_OFF:    p = PAT_OFF;
         MODE_CHASE:  p = PAT_CHASE;
         MODE_BOUNCE: p = PAT_BOUNCE;
         MODE_BLINK:  p = PAT_BLINK;
         default:     p = PAT_OFF;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Interface: led_pattern_sequencer_if
// Mode-request valid/ready handshake between a host/button block and the
// sequencer.
//   MODE_IN    : requested mode (master -> slave)
//   MODE_VALID : MODE_IN valid, held until accepted (master -> slave)
//   MODE_READY : sequencer can accept a mode this cycle (slave -> master)
interface led_pattern_sequencer_if;
   import led_seq_pkg::*;

   mode_t MODE_IN;
   logic  MODE_VALID;
   logic  MODE_READY;

   modport master (output MODE_IN, output MODE_VALID, input  MODE_READY);
   modport slave  (input  MODE_IN, input  MODE_VALID, output MODE_READY);

endinterface

// File: rtl/led_pattern_sequencer_prescaler.sv
// Module: tick_prescaler
// Free-running step-tick divider. Counts 0..DIV-1 while en is high and wraps;
// tick is high during the cycle the count sits at DIV-1.
//   CLK_IN : clock
//   RST_IN : asynchronous active-high reset (count -> 0)
//   clr    : synchronous clear, overrides en
//   en     : count enable
//   tick   : step strobe
module tick_prescaler #(
   parameter int unsigned DIV = 1500000,
   parameter int unsigned W   = 21
) (
   input  logic CLK_IN,
   input  logic RST_IN,
   input  logic clr,
   input  logic en,
   output logic tick
);

   if ((DIV < 2) || (longint'(DIV) > (longint'(1) << W))) begin : g_bad_div
      $error("tick_prescaler: DIV must be >= 2 and fit in W bits");
   end

   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      end
   end

   assign tick = en && !clr && (r_count == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Module: led_pattern_sequencer
// Drives GLED5 and RLED1..RLED4 with one of four patterns, stepping once per
// prescaler tick. Modes arrive over a valid/ready handshake.
//   CLK_IN        : system clock
//   RST_IN        : asynchronous active-high reset
//   mode_if       : slave side of the mode handshake (MODE_IN/VALID/READY)
//   GLED5         : heartbeat (toggles per tick in RUN, 1 when idle)
//   RLED1..RLED4  : pattern bits 0..3
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned PRESCALE_DIV = 1500000,
   parameter int unsigned PRESCALE_W   = 21
) (
   input  logic                    CLK_IN,
   input  logic                    RST_IN,
   led_pattern_sequencer_if.slave  mode_if,
   output logic                    GLED5,
   output logic                    RLED1,
   output logic                    RLED2,
   output logic                    RLED3,
   output logic                    RLED4
);

   state_t     r_state;
   mode_t      r_mode;
   logic [3:0] r_pattern;
   logic       r_gled;
   logic       r_dir;     // 1: bounce moving toward bit 3
   logic       r_ready;

   logic w_accept;
   logic w_tick;
   logic w_run;

   assign w_run    = (r_state == ST_RUN);
   assign w_accept = mode_if.MODE_VALID && r_ready;

   // Prescaler only advances in RUN; IDLE and LOAD hold it at zero so the
   // first step lands exactly PRESCALE_DIV cycles after RUN entry.
   tick_prescaler #(
      .DIV (PRESCALE_DIV),
      .W   (PRESCALE_W)
   ) u_prescaler (
      .CLK_IN (CLK_IN),
      .RST_IN (RST_IN),
      .clr    (!w_run),
      .en     (w_run),
      .tick   (w_tick)
   );

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_state   <= ST_IDLE;
         r_mode    <= MODE_OFF;
         r_pattern <= '0;
         r_gled    <= 1'b0;
         r_dir     <= 1'b1;
         r_ready   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pattern <= '0;
               r_gled    <= 1'b1;
               if (w_accept) begin
                  r_mode  <= mode_if.MODE_IN;
                  r_ready <= 1'b0;
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               r_ready   <= 1'b1;
               r_gled    <= 1'b1;
               r_dir     <= 1'b1;
               r_pattern <= init_pattern(r_mode);
               r_state   <= (r_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
               // A request arriving on the tick edge wins; that step is dropped.
               if (w_accept) begin
                  r_mode  <= mode_if.MODE_IN;
                  r_ready <= 1'b0;
                  r_state <= ST_LOAD;
               end else if (w_tick) begin
                  r_gled <= ~r_gled;
                  case (r_mode)
                     MODE_CHASE: r_pattern <= {r_pattern[2:0], r_pattern[3]};
                     MODE_BOUNCE: begin
                        if (r_dir) begin
                           if (r_pattern[3]) begin
                              r_pattern <= 4'b0100;
                              r_dir     <= 1'b0;
                           end else begin
                              r_pattern <= {r_pattern[2:0], 1'b0};
                           end
                        end else begin
                           if (r_pattern[0]) begin
                              r_pattern <= 4'b0010;
                              r_dir     <= 1'b1;
                           end else begin
                              r_pattern <= {1'b0, r_pattern[3:1]};
                           end
                        end
                     end
                     MODE_BLINK: r_pattern <= ~r_pattern;
                     default:    r_pattern <= r_pattern;
                  endcase
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign mode_if.MODE_READY = r_ready;
   assign GLED5 = r_gled;
   assign RLED1 = r_pattern[0];
   assign RLED2 = r_pattern[1];
   assign RLED3 = r_pattern[2];
   assign RLED4 = r_pattern[3];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench: tb_led_pattern_sequencer
// Directed stimulus with a scoreboard queue; DIV=4 so steps are 4 cycles apart.
module tb_led_pattern_sequencer;
   import led_seq_pkg::*;

   typedef struct {
      string      tag;
      logic [5:0] exp;   // {GLED5, RLED4..RLED1, MODE_READY}
   } exp_t;

   logic clk;
   logic rst;
   logic gled5, rled1, rled2, rled3, rled4;

   exp_t sb[$];
   int   n_tests;
   int   n_fail;

   led_pattern_sequencer_if mif ();

   led_pattern_sequencer #(
      .PRESCALE_DIV (4),
      .PRESCALE_W   (3)
   ) dut (
      .CLK_IN  (clk),
      .RST_IN  (rst),
      .mode_if (mif),
      .GLED5   (gled5),
      .RLED1   (rled1),
      .RLED2   (rled2),
      .RLED3   (rled3),
      .RLED4   (rled4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push(input string tag, input logic g, input logic [3:0] pat,
                       input logic rdy);
      exp_t e;
      e.tag = tag;
      e.exp = {g, pat, rdy};
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t       e;
      logic [5:0] obs;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
      end else begin
         e   = sb.pop_front();
         obs = {gled5, rled4, rled3, rled2, rled1, mif.MODE_READY};
         n_tests++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic step(input string tag, input logic g, input logic [3:0] pat);
      push(tag, g, pat, 1'b1);
      check();
   endtask

   // Drive one request at a negedge; check the LOAD cycle (ready low, LEDs
   // unchanged) and then the LOAD outputs one cycle later.
   task automatic send_mode(input string tag, input mode_t m,
                            input logic prev_g, input logic [3:0] prev_pat,
                            input logic [3:0] init_pat);
      mif.MODE_IN    = m;
      mif.MODE_VALID = 1'b1;
      @(negedge clk);
      mif.MODE_VALID = 1'b0;
      push({tag, "_load"}, prev_g, prev_pat, 1'b0);
      check();
      @(negedge clk);
      push({tag, "_init"}, 1'b1, init_pat, 1'b1);
      check();
   endtask

   logic [3:0] bounce_seq [6];
   logic       bounce_g   [6];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      mif.MODE_IN    = MODE_OFF;
      mif.MODE_VALID = 1'b0;
      rst = 1'b0;
      bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      bounce_g   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // 1. Asynchronous reset with no clock edge, then release
      #2 rst = 1'b1;
      #1;
      push("reset_async", 1'b0, 4'b0000, 1'b1);
      check();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      step("idle_after_release", 1'b1, 4'b0000);

      // 2. CHASE
      send_mode("chase", MODE_CHASE, 1'b1, 4'b0000, 4'b0001);
      cyc(3); step("chase_hold", 1'b1, 4'b0001);
      cyc(1); step("chase_s1",   1'b0, 4'b0010);
      cyc(4); step("chase_s2",   1'b1, 4'b0100);
      cyc(4); step("chase_s3",   1'b0, 4'b1000);
      cyc(4); step("chase_wrap", 1'b1, 4'b0001);

      // 3. BOUNCE (request lands mid-interval, no tick conflict)
      send_mode("bounce", MODE_BOUNCE, 1'b1, 4'b0001, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         cyc(4);
         step($sformatf("bounce_s%0d", i + 1), bounce_g[i], bounce_seq[i]);
      end

      // 4. BLINK, then OFF back to IDLE
      send_mode("blink", MODE_BLINK, 1'b1, 4'b0001, 4'b1111);
      cyc(4); step("blink_s1", 1'b0, 4'b0000);
      cyc(4); step("blink_s2", 1'b1, 4'b1111);
      send_mode("off", MODE_OFF, 1'b1, 4'b1111, 4'b0000);
      cyc(1); step("off_idle",      1'b1, 4'b0000);
      cyc(6); step("off_idle_hold", 1'b1, 4'b0000);

      // 5. Request on the exact tick edge: accept wins, 1000 step dropped
      send_mode("chase2", MODE_CHASE, 1'b1, 4'b0000, 4'b0001);
      cyc(4); step("chase2_s1", 1'b0, 4'b0010);
      cyc(4); step("chase2_s2", 1'b1, 4'b0100);
      cyc(3);
      send_mode("blink_tick", MODE_BLINK, 1'b1, 4'b0100, 4'b1111);
      cyc(3); step("blink_tick_hold", 1'b1, 4'b1111);
      cyc(1); step("blink_tick_s1",   1'b0, 4'b0000);

      // 6. Reset pulse mid-BOUNCE, then restart CHASE
      send_mode("bounce2", MODE_BOUNCE, 1'b0, 4'b0000, 4'b0001);
      cyc(4); step("bounce2_s1", 1'b0, 4'b0010);
      cyc(4); step("bounce2_s2", 1'b1, 4'b0100);
      cyc(4); step("bounce2_s3", 1'b0, 4'b1000);
      #2 rst = 1'b1;
      #1;
      push("reset_mid_run", 1'b0, 4'b0000, 1'b1);
      check();
      #1 rst = 1'b0;
      @(negedge clk);
      step("idle_after_midreset", 1'b1, 4'b0000);
      send_mode("chase3", MODE_CHASE, 1'b1, 4'b0000, 4'b0001);
      cyc(4); step("chase3_s1", 1'b0, 4'b0010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
